// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared encodings for the IF/MEM memory-bus arbiter.
// State and owner encodings are fixed so debug taps and checkers can decode
// them without referring back to the RTL.
package mem_bus_arbiter_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ArbIdle = 2'b00,
        ArbBusy = 2'b01,
        ArbAck  = 2'b10
    } arb_state_e;

    // Which requester currently owns the RAM.
    typedef enum logic [1:0] {
        ArbOwnNone = 2'b00,
        ArbOwnIf   = 2'b01,
        ArbOwnMem  = 2'b10
    } arb_owner_e;

    // RAM control levels.
    localparam logic ChipEnable   = 1'b1;
    localparam logic ChipDisable  = 1'b0;
    localparam logic WriteDisable = 1'b0;

    // Wait-state counter width; covers the legal latency range 1..15.
    localparam int CntW = 4;

    // Width of each performance counter.
    localparam int PerfCntW = 32;

endpackage

// File: rtl/mem_bus_arb_perf_cnt.sv
// mem_bus_arb_perf_cnt: saturating event counter with synchronous clear.
// Used twice by mem_bus_arbiter when MEM_BUS_ARB_PERF_CNT_EN is defined.
module mem_bus_arb_perf_cnt
    import mem_bus_arbiter_pkg::*;
#(
    parameter int W = PerfCntW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count event cycles, stick at all-ones, clear has priority over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one fixed-latency single-port RAM between the
// instruction-fetch (IF) and memory-access (MEM) pipeline stages.
//
// Handshake: a requester raises req with stable address/data and holds it
// until it sees a one-cycle ack; ack marks completion, and read data is valid
// only in the ack cycle. The requester must drop or renew req the cycle after
// ack. A req dropped mid-access still completes and still receives its ack.
// MEM has fixed priority over IF since it holds the older instruction.
//
// Optional build macro: MEM_BUS_ARB_PERF_CNT_EN adds perf_clr and the
// saturating if_stall_cnt / mem_stall_cnt outputs.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    // IF port (read only)
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    // MEM port
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] mem_sel,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_ack,
    // RAM side
    output logic                ram_ce,
    output logic                ram_we,
    output logic [DATA_W/8-1:0] ram_sel,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    // Pipeline stall requests
    output logic                if_stall,
    output logic                mem_stall,
`ifdef MEM_BUS_ARB_PERF_CNT_EN
    input  logic                perf_clr,
    output logic [31:0]         if_stall_cnt,
    output logic [31:0]         mem_stall_cnt,
`endif
    // Current FSM state, for debug and checkers
    output logic [1:0]          dbg_state
);

    localparam int SelW = DATA_W / 8;
    localparam logic [SelW-1:0]   ArbSelAll = {SelW{1'b1}};
    localparam logic [DATA_W-1:0] ZeroWord  = '0;
    localparam logic [CntW-1:0]   WaitInit  = CntW'(WAIT_CYCLES);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                ce_d, we_d;
    logic [SelW-1:0]     sel_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

    // Register all FSM state and the registered RAM interface.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ArbIdle;
            owner_q   <= ArbOwnNone;
            cnt_q     <= '0;
            rdata_q   <= ZeroWord;
            ram_ce    <= ChipDisable;
            ram_we    <= WriteDisable;
            ram_sel   <= '0;
            ram_addr  <= '0;
            ram_wdata <= ZeroWord;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            ram_ce    <= ce_d;
            ram_we    <= we_d;
            ram_sel   <= sel_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
        end
    end

    // Next-state logic: grant in IDLE, count wait states in BUSY, ack once.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ce_d    = ram_ce;
        we_d    = ram_we;
        sel_d   = ram_sel;
        addr_d  = ram_addr;
        wdata_d = ram_wdata;

        unique case (state_q)
            ArbIdle: begin
                if (mem_req) begin
                    owner_d = ArbOwnMem;
                    ce_d    = ChipEnable;
                    we_d    = mem_we;
                    sel_d   = mem_sel;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    cnt_d   = WaitInit;
                    state_d = ArbBusy;
                end else if (if_req) begin
                    owner_d = ArbOwnIf;
                    ce_d    = ChipEnable;
                    we_d    = WriteDisable;
                    sel_d   = ArbSelAll;
                    addr_d  = if_addr;
                    wdata_d = ZeroWord;
                    cnt_d   = WaitInit;
                    state_d = ArbBusy;
                end
            end
            ArbBusy: begin
                // RAM inputs stay put; the last wait cycle samples the data.
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    rdata_d = ram_rdata;
                    ce_d    = ChipDisable;
                    we_d    = WriteDisable;
                    state_d = ArbAck;
                end
            end
            ArbAck: begin
                owner_d = ArbOwnNone;
                state_d = ArbIdle;
            end
            default: begin
                owner_d = ArbOwnNone;
                state_d = ArbIdle;
            end
        endcase
    end

    // Acks are decoded from ACK state and owner, so they are exclusive by construction.
    always_comb begin
        if_ack  = (state_q == ArbAck) && (owner_q == ArbOwnIf);
        mem_ack = (state_q == ArbAck) && (owner_q == ArbOwnMem);
    end

    assign if_rdata  = rdata_q;
    assign mem_rdata = rdata_q;
    assign if_stall  = if_req  & ~if_ack;
    assign mem_stall = mem_req & ~mem_ack;
    assign dbg_state = state_q;

`ifdef MEM_BUS_ARB_PERF_CNT_EN
    mem_bus_arb_perf_cnt #(.W(32)) u_if_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (perf_clr),
        .inc (if_stall),
        .cnt (if_stall_cnt)
    );

    mem_bus_arb_perf_cnt #(.W(32)) u_mem_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (perf_clr),
        .inc (mem_stall),
        .cnt (mem_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: self-checking bench for mem_bus_arbiter (WAIT_CYCLES=2).
// Expected timing comes from the access rules: a lone request is acked
// W+1 cycles after it is seen, a second queued request W+2 cycles later.
// Read data comes from a reference memory updated per transaction.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = DATA_W / 8;
    localparam int W      = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              mem_req;
    logic              mem_we;
    logic [SEL_W-1:0]  mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              ram_ce;
    logic              ram_we;
    logic [SEL_W-1:0]  ram_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              if_stall;
    logic              mem_stall;
    logic [1:0]        dbg_state;
`ifdef MEM_BUS_ARB_PERF_CNT_EN
    logic              perf_clr;
    logic [31:0]       if_stall_cnt;
    logic [31:0]       mem_stall_cnt;
`endif

    mem_bus_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_CYCLES (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_rdata      (if_rdata),
        .if_ack        (if_ack),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_sel       (mem_sel),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .ram_ce        (ram_ce),
        .ram_we        (ram_we),
        .ram_sel       (ram_sel),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .if_stall      (if_stall),
        .mem_stall     (mem_stall),
`ifdef MEM_BUS_ARB_PERF_CNT_EN
        .perf_clr      (perf_clr),
        .if_stall_cnt  (if_stall_cnt),
        .mem_stall_cnt (mem_stall_cnt),
`endif
        .dbg_state     (dbg_state)
    );

    // ---------------- RAM stand-in ----------------
    // Data is only presented once ce has been high for W-1 full cycles,
    // so sampling too early returns a poison word.
    logic [DATA_W-1:0] ram_arr [0:1023];
    int ce_age = 0;

    always @(posedge clk) begin
        if (ram_ce) ce_age <= ce_age + 1;
        else        ce_age <= 0;
        if (ram_ce && ram_we) begin
            for (int b = 0; b < SEL_W; b++)
                if (ram_sel[b]) ram_arr[ram_addr[9:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    assign ram_rdata = (ram_ce && ce_age >= W-1) ? ram_arr[ram_addr[9:0]] : 32'hBADB_AD00;

    // ---------------- reference model / scoreboard ----------------
    logic [DATA_W-1:0] ref_mem [0:1023];
    logic [DATA_W-1:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] sel);
        merge_bytes = old_w;
        for (int b = 0; b < 4; b++)
            if (sel[b]) merge_bytes[8*b +: 8] = new_w[8*b +: 8];
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ce"},    32'(ram_ce),    32'd0);
        check_eq({tag, "_we"},    32'(ram_we),    32'd0);
        check_eq({tag, "_sel"},   32'(ram_sel),   32'd0);
        check_eq({tag, "_addr"},  ram_addr,       32'd0);
        check_eq({tag, "_wdata"}, ram_wdata,      32'd0);
        check_eq({tag, "_ifack"}, 32'(if_ack),    32'd0);
        check_eq({tag, "_mack"},  32'(mem_ack),   32'd0);
        check_eq({tag, "_rdata"}, if_rdata,       32'd0);
        check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1 with the arbiter idle. Cycle 0 is the cycle in which
    // the requests are first visible; each cycle is sampled at its negedge.
    task automatic run_round(input bit use_if, input bit use_mem, input bit drop_if,
                             input logic [31:0] ia, input logic [31:0] ma, input bit we,
                             input logic [3:0] sel, input logic [31:0] wd);
        int mem_cyc, if_cyc, last_c;
        bit in_mem_win, in_if_win, is_ack;
        logic [31:0] exp_d, got_d;
        mem_cyc = use_mem ? W + 1 : -1;
        if_cyc  = use_if ? (use_mem ? 2*W + 3 : W + 1) : -1;
        last_c  = (use_if && use_mem) ? 2*W + 5 : W + 3;

        // Service order is MEM then IF; expected reads are queued in that order.
        if (use_mem) begin
            if (we) ref_mem[ma[9:0]] = merge_bytes(ref_mem[ma[9:0]], wd, sel);
            else    exp_q.push_back(ref_mem[ma[9:0]]);
        end
        if (use_if) exp_q.push_back(ref_mem[ia[9:0]]);

        if_req    = use_if;
        if_addr   = ia;
        mem_req   = use_mem;
        mem_we    = we;
        mem_sel   = sel;
        mem_addr  = ma;
        mem_wdata = wd;

        for (int c = 0; c <= last_c; c++) begin
            @(negedge clk);
            in_mem_win = use_mem && c >= 1 && c <= W;
            in_if_win  = use_if && (use_mem ? (c >= W+3 && c <= 2*W+2) : (c >= 1 && c <= W));
            is_ack     = (c == mem_cyc) || (c == if_cyc);
            check_eq($sformatf("mem_ack_c%0d", c),   32'(mem_ack),   32'(c == mem_cyc));
            check_eq($sformatf("if_ack_c%0d", c),    32'(if_ack),    32'(c == if_cyc));
            check_eq($sformatf("if_stall_c%0d", c),  32'(if_stall),  32'(if_req && c != if_cyc));
            check_eq($sformatf("mem_stall_c%0d", c), 32'(mem_stall), 32'(mem_req && c != mem_cyc));
            check_eq($sformatf("ram_ce_c%0d", c),    32'(ram_ce),    32'(in_mem_win || in_if_win));
            check_eq($sformatf("state_c%0d", c),     32'(dbg_state),
                     (in_mem_win || in_if_win) ? 32'd1 : (is_ack ? 32'd2 : 32'd0));
            if (in_mem_win) begin
                check_eq("mem_ram_we",    32'(ram_we),  32'(we));
                check_eq("mem_ram_sel",   32'(ram_sel), 32'(sel));
                check_eq("mem_ram_addr",  ram_addr,     ma);
                check_eq("mem_ram_wdata", ram_wdata,    wd);
            end else if (in_if_win) begin
                check_eq("if_ram_we",    32'(ram_we),  32'd0);
                check_eq("if_ram_sel",   32'(ram_sel), 32'hF);
                check_eq("if_ram_addr",  ram_addr,     ia);
                check_eq("if_ram_wdata", ram_wdata,    32'd0);
            end else begin
                check_eq($sformatf("ram_we_off_c%0d", c), 32'(ram_we), 32'd0);
            end
            if ((c == mem_cyc && !we) || c == if_cyc) begin
                got_d = (c == mem_cyc) ? mem_rdata : if_rdata;
                if (exp_q.size() == 0) begin
                    check_eq("exp_q_underflow", 32'd0, 32'd1);
                end else begin
                    exp_d = exp_q.pop_front();
                    check_eq((c == mem_cyc) ? "mem_rdata" : "if_rdata", got_d, exp_d);
                end
            end
            @(posedge clk);
            #1;
            if (c == mem_cyc) mem_req = 1'b0;
            if (c == if_cyc)  if_req  = 1'b0;
            if (drop_if && c == 0) if_req = 1'b0;
        end
        check_eq("exp_q_drained", exp_q.size(), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int kind, gap;
        logic [31:0] r_ia, r_ma, r_wd;
        logic [3:0]  r_sel;
        bit          r_we;

        for (int i = 0; i < 1024; i++) begin
            r_wd       = $urandom;
            ram_arr[i] <= r_wd;
            ref_mem[i] = r_wd;
        end
        ram_arr[16]  <= 32'h2401_0005;
        ref_mem[16]  = 32'h2401_0005;
        ram_arr[256] <= 32'h0000_0000;
        ref_mem[256] = 32'h0000_0000;

        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
`ifdef MEM_BUS_ARB_PERF_CNT_EN
        perf_clr = 1'b0;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        check_eq("rst_if_stall", 32'(if_stall), 32'd0);
`ifdef MEM_BUS_ARB_PERF_CNT_EN
        check_eq("rst_if_scnt",  if_stall_cnt,  32'd0);
        check_eq("rst_mem_scnt", mem_stall_cnt, 32'd0);
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;

        // IF read of a known word
        run_round(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 4'h0, 32'h0);
        // MEM partial write, then read back the merged word
        run_round(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        run_round(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 1'b0, 4'hF, 32'h0);

        // Same-cycle IF and MEM requests
`ifdef MEM_BUS_ARB_PERF_CNT_EN
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
`endif
        run_round(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0004, 1'b0, 4'hF, 32'h0);
`ifdef MEM_BUS_ARB_PERF_CNT_EN
        @(negedge clk);
        check_eq("perf_if_cnt",  if_stall_cnt,  32'd7);
        check_eq("perf_mem_cnt", mem_stall_cnt, 32'd3);
        @(posedge clk);
        #1;
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        check_eq("perf_if_clr",  if_stall_cnt,  32'd0);
        check_eq("perf_mem_clr", mem_stall_cnt, 32'd0);
`endif

        // IF request dropped in cycle 1
        run_round(1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h0, 1'b0, 4'h0, 32'h0);

        // Reset in the middle of a MEM read
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_000C; mem_wdata = 32'h0;
        @(posedge clk);
        #1;
        check_eq("pre_rst_ce", 32'(ram_ce), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check_idle_outputs("midrst");
        mem_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < W + 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("post_rst_mack_c%0d", c), 32'(mem_ack), 32'd0);
            check_eq($sformatf("post_rst_ce_c%0d", c),   32'(ram_ce),  32'd0);
        end
        @(posedge clk);
        #1;
        run_round(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 4'h0, 32'h0);

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            kind  = int'($urandom_range(0, 3));
            r_ia  = $urandom_range(0, 31);
            r_ma  = $urandom_range(0, 31);
            r_we  = 1'($urandom_range(0, 1));
            r_sel = 4'($urandom_range(1, 15));
            r_wd  = $urandom;
            run_round(kind != 1, kind == 1 || kind == 2, kind == 3, r_ia, r_ma, r_we, r_sel, r_wd);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port, fixed-latency data RAM between the instruction-fetch stage (IF port) and the memory-access stage (MEM port).
- Sequences each access with a small FSM and a wait-state counter, and returns an acknowledge pulse with the read data.
- Raises combinational stall requests to the pipeline controller while either requester is waiting.
- Sits between the IF/MEM stages and the RAM wrapper.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte-select width is DATA_W/8.
- WAIT_CYCLES, 2, RAM read latency in cycles, legal range 1..15; the RAM inputs are held stable for the whole count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request; held until if_ack.
- if_addr  in  ADDR_W  IF word address.
- if_rdata  out  DATA_W  IF read data; valid only while if_ack=1.
- if_ack  out  1  one-cycle completion pulse for IF.
- mem_req  in  1  MEM request; held until mem_ack.
- mem_we  in  1  MEM write enable.
- mem_sel  in  DATA_W/8  MEM byte selects.
- mem_addr  in  ADDR_W  MEM address.
- mem_wdata  in  DATA_W  MEM write data.
- mem_rdata  out  DATA_W  MEM read data; valid only while mem_ack=1.
- mem_ack  out  1  one-cycle completion pulse for MEM.
- ram_ce  out  1  RAM chip enable.
- ram_we  out  1  RAM write enable.
- ram_sel  out  DATA_W/8  RAM byte selects.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid WAIT_CYCLES cycles after ram_ce rises.
- if_stall  out  1  stall request = if_req & ~if_ack (combinational).
- mem_stall  out  1  stall request = mem_req & ~mem_ack (combinational).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=NONE.
  - ram_ce, ram_we, ram_sel, ram_addr, ram_wdata all 0.
  - rdata register=0; both acks 0.
  - Reset mid-access aborts the access immediately; no ack is issued afterwards.
- States: IDLE, BUSY, ACK (encodings 2'b00, 2'b01, 2'b10).
- IDLE:
  - If mem_req=1, grant MEM. Else if if_req=1, grant IF. MEM has fixed priority because it holds the older instruction.
  - On the grant edge, register the RAM outputs:
    - ram_ce=1.
    - For MEM: ram_we=mem_we, ram_sel=mem_sel, ram_addr=mem_addr, ram_wdata=mem_wdata.
    - For IF: ram_we=0, ram_sel=all ones, ram_wdata=0, ram_addr=if_addr.
  - Set cnt=WAIT_CYCLES and go to BUSY.
- BUSY:
  - RAM outputs are held constant; cnt decrements each cycle.
  - On the edge where cnt==1: capture ram_rdata into the rdata register, set ram_ce=0 and ram_we=0, and go to ACK.
- ACK:
  - The owner's ack=1 for exactly this cycle; if_rdata=mem_rdata=rdata register.
  - No grant is made in this state. Next state is IDLE, with owner cleared to NONE.
  - The requester must drop or renew its req on the next cycle.
- Latency: a request seen in IDLE at cycle 0 gets its ack at cycle WAIT_CYCLES+1. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Writes follow the same timing. The ack confirms completion, and the rdata captured during a write is don't-care.
- If req drops during BUSY, the access still completes and the ack is still pulsed (ignored by the requester).
- Simultaneous IF and MEM requests: MEM is served first. IF stays stalled and is granted in the next IDLE, provided mem_req is low then.
- Acks are mutually exclusive and are never asserted outside ACK.
- rdata outputs hold their last captured value when ack=0.

Optional Feature:
- Macro: MEM_BUS_ARB_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs if_stall_cnt and mem_stall_cnt.
  - Each counts cycles its stall output is 1 and saturates at 32'hFFFF_FFFF.
  - Both reset to 0 and are cleared synchronously by an added input perf_clr (1 bit).
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- defines.v gains:
  - state encodings `ArbIdle`, `ArbBusy`, `ArbAck`;
  - owner encodings `ArbOwnNone`, `ArbOwnIf`, `ArbOwnMem`;
  - `ArbSelAll`.
- Existing `ChipEnable`, `ChipDisable`, `WriteEnable`, `WriteDisable`, and `ZeroWord` are reused.
- One natural sub-module, mem_bus_arb_perf_cnt: a saturating counter instantiated twice, only under the macro.

Test Plan (WAIT_CYCLES=2):
- Reset mid-BUSY of a MEM read → all ram_* outputs 0 on the reset edge; no ack after release; IF request then served normally.
- IF read, if_addr=32'h0000_0010, RAM returns 32'h2401_0005 → ram_ce high cycles 1–2, if_ack at cycle 3 with if_rdata=32'h2401_0005, if_stall=1 for cycles 0–2.
- MEM write, addr=32'h0000_0100, sel=4'b0011, wdata=32'hDEAD_BEEF → ram_we=1 and ram_sel=4'b0011 for cycles 1–2; mem_ack at cycle 3; read-back returns 32'h0000_BEEF in the low half.
- Same-cycle if_req and mem_req → mem_ack at cycle 3, if_ack at cycle 7; if_stall is 1 for cycles 0–6.
- IF req dropped in cycle 1 → ack still pulses at cycle 3; the next grant begins no earlier than cycle 4.
- With MEM_BUS_ARB_PERF_CNT_EN: the scenario above yields if_stall_cnt=7 and mem_stall_cnt=3; perf_clr=1 → both 0 on the next edge.
